stage_writeback_lsu: RTL and testbench

STAGE_WRITEBACK_LSU -- requirements
Module: stage_writeback_lsu

---
 rtl/wb_pkg.sv | 35 +++
 rtl/load_extend.sv | 30 +++
 rtl/stage_writeback_lsu.sv | 147 ++++++++++++++
 tb/tb_stage_writeback_lsu.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback/load-extend stage: result source select,
// load funct3 codes, FSM states and a load legality helper.
package wb_pkg;

  typedef enum logic [1:0] {
    SrcAlu  = 2'b00,
    SrcLoad = 2'b01,
    SrcPc4  = 2'b10,
    SrcImm  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic {
    StIdle,
    StWaitLoad
  } wb_state_e;

  // A load is legal when funct3 is a known load type and the offset is naturally aligned.
  function automatic logic load_legal(input logic [2:0] funct3, input logic [1:0] byte_off);
    logic ok;
    case (funct3)
      F3Lb, F3Lbu: ok = 1'b1;
      F3Lh, F3Lhu: ok = ~byte_off[0];
      F3Lw:        ok = (byte_off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment: picks the byte/halfword at byte_off out of
// the returned word and sign- or zero-extends it to XLEN.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      byte_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
    half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (funct3_i)
      F3Lb:    result_o = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      F3Lbu:   result_o = {{(XLEN - 8){1'b0}}, byte_sel};
      F3Lh:    result_o = {{(XLEN - 16){half_sel[15]}}, half_sel};
      F3Lhu:   result_o = {{(XLEN - 16){1'b0}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_writeback_lsu.sv
// Writeback stage with a single outstanding load: selects the result source, waits
// (with timeout) for load data, aligns/extends it and drives a registered RF write port.
module stage_writeback_lsu
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_result_src,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_pc_plus_4,
  input  logic [XLEN-1:0]    in_imm_ext,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_byte_off,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  wb_state_e          state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               err_q, err_d;

  logic [XLEN-1:0]    src_data;
  logic [XLEN-1:0]    load_data;
  logic               wr_en_req;

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .funct3_i  (f3_q),
    .byte_off_i(off_q),
    .rdata_i   (mem_rdata),
    .result_o  (load_data)
  );

  always_comb begin
    unique case (result_src_e'(in_result_src))
      SrcAlu:  src_data = in_alu_result;
      SrcPc4:  src_data = in_pc_plus_4;
      SrcImm:  src_data = in_imm_ext;
      default: src_data = in_alu_result;
    endcase
  end

  assign wr_en_req = in_reg_write && (in_rd != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (result_src_e'(in_result_src) == SrcLoad) begin
            if (!load_legal(in_funct3, in_byte_off)) begin
              err_d = 1'b1;
            end else if (wr_en_req) begin
              rd_d    = in_rd;
              f3_d    = in_funct3;
              off_d   = in_byte_off;
              cnt_d   = '0;
              state_d = StWaitLoad;
            end
          end else if (wr_en_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = src_data;
          end
        end
      end
      StWaitLoad: begin
        // Data takes priority over a timeout landing in the same cycle.
        if (mem_rvalid) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = rd_q;
          rf_wdata_d = load_data;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutCnt) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q == StWaitLoad);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_stage_writeback_lsu.sv
// Directed bench for stage_writeback_lsu: each task drives one scenario and checks
// outputs 1ns after the rising edge against hand-computed values.
module tb_stage_writeback_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_result_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_imm_ext;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [2:0]  in_funct3;
  logic [1:0]  in_byte_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_writeback_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result_src(in_result_src),
    .in_alu_result(in_alu_result),
    .in_pc_plus_4 (in_pc_plus_4),
    .in_imm_ext   (in_imm_ext),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_funct3    (in_funct3),
    .in_byte_off  (in_byte_off),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .err          (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid      = 1'b0;
    in_result_src = 2'b00;
    in_alu_result = '0;
    in_pc_plus_4  = '0;
    in_imm_ext    = '0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
    in_funct3     = 3'b000;
    in_byte_off   = 2'b00;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic issue_alu(input logic [1:0] src, input logic [31:0] val, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_result_src = src;
    in_alu_result = (src == 2'b00) ? val : 32'hDEAD_0000;
    in_pc_plus_4  = (src == 2'b10) ? val : 32'hDEAD_0001;
    in_imm_ext    = (src == 2'b11) ? val : 32'hDEAD_0002;
    in_rd         = rd;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Issue a load, hold off rvalid for `waits` busy cycles, then return data; bcnt counts busy cycles.
  task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits, output int bcnt);
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = f3;
    in_byte_off   = off;
    in_rd         = rd;
    in_reg_write  = 1'b1;
    mem_rdata     = rdata;
    step();
    in_valid = 1'b0;
    bcnt     = 0;
    for (int i = 0; i <= waits; i++) begin
      if (busy === 1'b1) bcnt++;
      mem_rvalid = (i == waits);
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, err, busy} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b waddr=%0d wdata=%h err=%0b busy=%0b want all 0",
               rf_we, rf_waddr, rf_wdata, err, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_alu_sources();
    issue_alu(2'b00, 32'h1234_5678, 5'd5);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_write got we=%0b waddr=%0d wdata=%h want 1/5/12345678",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL we_pulse_hold got we=%0b waddr=%0d wdata=%h want 0/5/12345678",
               rf_we, rf_waddr, rf_wdata);
    end
    issue_alu(2'b10, 32'h0000_0104, 5'd6);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h0000_0104) begin
      errors++;
      $display("FAIL pc4_write got we=%0b waddr=%0d wdata=%h want 1/6/00000104",
               rf_we, rf_waddr, rf_wdata);
    end
    issue_alu(2'b11, 32'hFFFF_F800, 5'd31);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'hFFFF_F800) begin
      errors++;
      $display("FAIL imm_write got we=%0b waddr=%0d wdata=%h want 1/31/fffff800",
               rf_we, rf_waddr, rf_wdata);
    end
    step();
  endtask

  task automatic test_loads();
    int bc;
    run_load(3'b000, 2'd3, 5'd7, 32'h80FF_FFFF, 3, bc);
    checks++;
    if (bc != 4 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_off3 got busy_cycles=%0d we=%0b waddr=%0d wdata=%h want 4/1/7/ffffff80",
               bc, rf_we, rf_waddr, rf_wdata);
    end
    run_load(3'b100, 2'd3, 5'd8, 32'h80FF_FFFF, 3, bc);
    checks++;
    if (bc != 4 || rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_off3 got busy_cycles=%0d we=%0b waddr=%0d wdata=%h want 4/1/8/00000080",
               bc, rf_we, rf_waddr, rf_wdata);
    end
    run_load(3'b001, 2'd2, 5'd9, 32'h8001_7FFF, 0, bc);
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_off2 got we=%0b wdata=%h want 1/ffff8001", rf_we, rf_wdata);
    end
    run_load(3'b101, 2'd0, 5'd10, 32'h1234_F00D, 1, bc);
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_F00D) begin
      errors++;
      $display("FAIL lhu_off0 got we=%0b wdata=%h want 1/0000f00d", rf_we, rf_wdata);
    end
    run_load(3'b000, 2'd1, 5'd11, 32'h0000_7F00, 0, bc);
    checks++;
    if (rf_wdata !== 32'h0000_007F) begin
      errors++;
      $display("FAIL lb_off1 got wdata=%h want 0000007f", rf_wdata);
    end
    // Back-to-back: the cycle after rvalid is IDLE and accepts a new request.
    run_load(3'b010, 2'd0, 5'd12, 32'hCAFE_BABE, 2, bc);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hCAFE_BABE || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lw_pass got we=%0b waddr=%0d wdata=%h ready=%0b want 1/12/cafebabe/1",
               rf_we, rf_waddr, rf_wdata, in_ready);
    end
    issue_alu(2'b00, 32'h0000_00AA, 5'd13);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'h0000_00AA || err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got we=%0b waddr=%0d wdata=%h err=%0b want 1/13/000000aa/0",
               rf_we, rf_waddr, rf_wdata, err);
    end
    step();
  endtask

  task automatic test_misalign();
    do_reset();
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = 3'b001;
    in_byte_off   = 2'd1;
    in_rd         = 5'd4;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || rf_we !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lh_misalign got err=%0b we=%0b ready=%0b busy=%0b want 1/0/1/0",
               err, rf_we, in_ready, busy);
    end
    do_reset();
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = 3'b011;
    in_byte_off   = 2'd0;
    in_rd         = 5'd4;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (err !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_funct3 got err=%0b we=%0b busy=%0b want 1/0/0", err, rf_we, busy);
    end
  endtask

  task automatic test_timeout();
    int bc;
    do_reset();
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = 3'b010;
    in_byte_off   = 2'd0;
    in_rd         = 5'd3;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) bc++;
      if (rf_we === 1'b1) bc += 100;
      step();
    end
    checks++;
    if (bc != 16 || err !== 1'b1 || in_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout got busy_cycles=%0d err=%0b ready=%0b we=%0b want 16/1/1/0",
               bc, err, in_ready, rf_we);
    end
    // Data on the last allowed wait cycle wins over the timeout.
    do_reset();
    run_load(3'b010, 2'd0, 5'd3, 32'h0BAD_F00D, 15, bc);
    checks++;
    if (bc != 16 || rf_we !== 1'b1 || rf_wdata !== 32'h0BAD_F00D || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge got busy_cycles=%0d we=%0b wdata=%h err=%0b want 16/1/0badf00d/0",
               bc, rf_we, rf_wdata, err);
    end
    step();
  endtask

  task automatic test_no_write();
    do_reset();
    issue_alu(2'b00, 32'h5555_5555, 5'd0);
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rd0_alu got we=%0b wdata=%h want 0/00000000", rf_we, rf_wdata);
    end
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = 3'b010;
    in_rd         = 5'd0;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd0_load got we=%0b busy=%0b ready=%0b want 0/0/1", rf_we, busy, in_ready);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid got we=%0b wdata=%h err=%0b want 0/00000000/0",
               rf_we, rf_wdata, err);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    issue_alu(2'b00, 32'h7777_7777, 5'd2);
    in_valid      = 1'b1;
    in_result_src = 2'b01;
    in_funct3     = 3'b010;
    in_rd         = 5'd9;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    step();
    mem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || err !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_wait got we=%0b waddr=%0d wdata=%h err=%0b busy=%0b ready=%0b",
               rf_we, rf_waddr, rf_wdata, err, busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_alu_sources();
    test_loads();
    test_misalign();
    test_timeout();
    test_no_write();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
